// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: triggered multi-channel probe capture with serial scan-out readout.
// Pre/post-trigger window in a circular buffer, read back oldest-first through SDO.
module cpu_trace_buffer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int DEPTH = 16,
    parameter int POST  = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NCH*WIDTH-1:0]     Probe,
    input  logic                     ProbeValid,
    input  logic                     Arm,
    input  logic [1:0]               TrigMode,
    input  logic [$clog2(NCH)-1:0]   TrigCh,
    input  logic [WIDTH-1:0]         TrigValue,
    input  logic                     ExtTrig,
    input  logic                     Test,
    input  logic                     SDI,
    output logic                     SDO,
    output logic [1:0]               State,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int TW = NCH * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(TW);

    typedef enum logic [1:0] {IDLE, ARMED, POSTS, DONE} state_t;

    state_t          state;
    logic [TW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr, postcnt, raddr;
    logic [AW:0]     rdpos;
    logic [BW-1:0]   bitcnt;
    logic [TW-1:0]   sh;
    logic [WIDTH-1:0] ch;
    logic            hit, restart, we, rd, load;

    assign ch      = Probe[TrigCh*WIDTH +: WIDTH];
    assign hit     = TrigMode == 2'b00 ? 1'b1 :
                     TrigMode == 2'b01 ? ch == TrigValue :
                     TrigMode == 2'b10 ? ch != TrigValue : ExtTrig;
    assign restart = Arm && !Test;
    assign we      = !restart && ProbeValid && (state == ARMED || state == POSTS);
    assign rd      = state == DONE && Test;
    assign load    = rd && bitcnt == '0 && rdpos < Count;
    // oldest retained entry sits Count slots behind the write pointer
    assign raddr   = wptr - Count[AW-1:0] + rdpos[AW-1:0];
    assign SDO     = sh[0];
    assign State   = state;

    always_ff @(posedge Clock)
        if (we) mem[wptr] <= Probe;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            wptr    <= '0;
            postcnt <= '0;
            Count   <= '0;
            rdpos   <= '0;
            bitcnt  <= '0;
            sh      <= '0;
        end else begin
            if (restart) begin
                state  <= ARMED;
                wptr   <= '0;
                Count  <= '0;
                rdpos  <= '0;
                bitcnt <= '0;
            end else if (we) begin
                wptr <= wptr + 1'b1;
                if (Count != (AW+1)'(DEPTH)) Count <= Count + 1'b1;
                if (state == ARMED && hit) begin
                    state   <= POST == 0 ? DONE : POSTS;
                    postcnt <= AW'(POST);
                end else if (state == POSTS) begin
                    postcnt <= postcnt - 1'b1;
                    if (postcnt == AW'(1)) state <= DONE;
                end
            end
            // restart needs Test low, so it never collides with the readout updates
            if (Test) begin
                sh <= load ? mem[raddr] : {SDI, sh[TW-1:1]};
                if (rd) begin
                    bitcnt <= bitcnt == BW'(TW-1) ? '0 : bitcnt + 1'b1;
                    if (load) rdpos <= rdpos + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: randomized scoreboard bench for cpu_trace_buffer.
// A queue-based reference model predicts State/Count/SDO; a negedge monitor compares.
module tb_cpu_trace_buffer;
    localparam int WIDTH = 16, NCH = 4, DEPTH = 16, POST = 8, TW = NCH * WIDTH;

    logic            Clock = 0, Reset = 1;
    logic [TW-1:0]   Probe = '0;
    logic            ProbeValid = 0, Arm = 0, ExtTrig = 0, Test = 0, SDI = 0;
    logic [1:0]      TrigMode = 0, TrigCh = 0;
    logic [WIDTH-1:0] TrigValue = '0;
    logic            SDO;
    logic [1:0]      State;
    logic [4:0]      Count;

    cpu_trace_buffer #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .POST(POST)) dut (
        .Clock(Clock), .Reset(Reset), .Probe(Probe), .ProbeValid(ProbeValid), .Arm(Arm),
        .TrigMode(TrigMode), .TrigCh(TrigCh), .TrigValue(TrigValue), .ExtTrig(ExtTrig),
        .Test(Test), .SDI(SDI), .SDO(SDO), .State(State), .Count(Count)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {int cyc; string name; int val;} exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge Clock) begin
        exp_t e;
        int act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.name == "state") act = int'(State);
            else if (e.name == "count") act = int'(Count);
            else act = int'(SDO);
            if (e.cyc < cyc) check({e.name, " stale"}, -1, e.val);
            else check(e.name, act, e.val);
        end
    end

    // reference model: entries since last arm (capped at DEPTH), sample counters, SDI histories
    int            ms = 0, nwr = 0, trig_at = 0, rd_t = 0;
    logic [TW-1:0] ent[$];
    bit            dh[$], ih[$];

    function automatic bit fires();
        logic [WIDTH-1:0] c;
        c = Probe[TrigCh*WIDTH +: WIDTH];
        case (TrigMode)
            2'd0: return 1'b1;
            2'd1: return c == TrigValue;
            2'd2: return c != TrigValue;
            default: return ExtTrig;
        endcase
    endfunction

    task automatic step();
        bit chk = 0;
        int sx = 0, k, j, t;
        logic [TW-1:0] e;
        if (Arm && !Test) begin
            ms = 1; nwr = 0; rd_t = 0; ent.delete(); dh.delete();
        end else if ((ms == 1 || ms == 2) && ProbeValid) begin
            ent.push_back(Probe);
            if (ent.size() > DEPTH) void'(ent.pop_front());
            nwr++;
            if (ms == 1 && fires()) begin
                trig_at = nwr;
                ms = POST == 0 ? 3 : 2;
            end else if (ms == 2 && nwr - trig_at == POST) ms = 3;
        end else if (ms == 3 && Test) begin
            rd_t++;
            dh.push_back(SDI);
            k = (rd_t - 1) / TW;
            j = (rd_t - 1) % TW;
            if (k < ent.size()) begin
                e = ent[k];
                sx = int'(e[j]);
            end else sx = int'(dh[rd_t - TW]);
            chk = 1;
        end else if (ms == 0 && Test) begin
            ih.push_back(SDI);
            t = ih.size();
            sx = t >= TW ? int'(ih[t - TW]) : 0;
            chk = 1;
        end
        q.push_back('{cyc + 1, "state", ms});
        q.push_back('{cyc + 1, "count", ent.size()});
        if (chk) q.push_back('{cyc + 1, "sdo", sx});
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #1;
        Reset = 1;
        #1;
        check("reset state", int'(State), 0);
        check("reset count", int'(Count), 0);
        check("reset sdo", int'(SDO), 0);
        @(posedge Clock);
        #1;
        Reset = 0;
        ms = 0; nwr = 0; rd_t = 0;
        ent.delete(); dh.delete(); ih.delete();
    endtask

    task automatic arm();
        Arm = 1; Test = 0; ProbeValid = 1'($urandom);
        step();
        Arm = 0; ProbeValid = 0;
    endtask

    task automatic sample(logic [TW-1:0] p);
        Probe = p; ProbeValid = 1;
        step();
        ProbeValid = 0;
    endtask

    task automatic readout(int n);
        int got = 0;
        ProbeValid = 0; Arm = 0;
        while (got < n) begin
            Test = $urandom_range(0, 4) != 0;
            SDI = 1'($urandom);
            if (Test) got++;
            step();
        end
        Test = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] p;
        do_reset();

        Test = 1;
        repeat (TW + 10) begin SDI = 1'($urandom); step(); end
        Test = 0; SDI = 0;

        TrigMode = 2'd1; TrigCh = 0; TrigValue = 16'h0010;
        arm();
        for (int i = 0; i <= 16; i++) begin
            while ($urandom_range(0, 3) == 0) step();
            p = {$urandom, $urandom};
            p[15:0] = 16'(2 * i);
            sample(p);
        end
        check("equal done state", int'(State), 3);
        check("equal count", int'(Count), 16);
        readout(16 * TW + 16);

        TrigMode = 2'd0;
        arm();
        for (int i = 0; i < 10; i++) sample({$urandom, $urandom});
        check("immediate done state", int'(State), 3);
        check("immediate count", int'(Count), 9);
        readout(9 * TW + 70);

        arm();
        for (int i = 0; i < 3; i++) sample({$urandom, $urandom});
        Arm = 1; ProbeValid = 1; Probe = {$urandom, $urandom};
        step();
        Arm = 0; ProbeValid = 0;
        check("arm in post state", int'(State), 1);
        check("arm in post count", int'(Count), 0);

        sample({$urandom, $urandom});
        sample({$urandom, $urandom});
        do_reset();
        arm();
        check("arm after reset", int'(State), 1);

        TrigMode = 2'd3;
        for (int i = 1; i <= 13; i++) begin
            ExtTrig = i == 3;
            sample({$urandom, $urandom});
        end
        ExtTrig = 0;
        check("external done state", int'(State), 3);
        check("external count", int'(Count), 11);
        Arm = 1; Test = 1; SDI = 1'($urandom);
        step();
        Arm = 0; Test = 0;
        check("arm ignored in test", int'(State), 3);

        repeat (3000) begin
            Arm = $urandom_range(0, 40) == 0;
            Test = $urandom_range(0, 3) == 0;
            ProbeValid = $urandom_range(0, 2) != 0;
            TrigMode = 2'($urandom);
            TrigCh = 2'($urandom);
            TrigValue = 16'($urandom_range(0, 7));
            for (int c = 0; c < NCH; c++) Probe[c*WIDTH +: WIDTH] = 16'($urandom_range(0, 7));
            ExtTrig = $urandom_range(0, 7) == 0;
            SDI = 1'($urandom);
            step();
        end
        Arm = 0; Test = 0; ProbeValid = 0;
        @(negedge Clock);
        #1;
        check("scoreboard drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per probe channel.
REQ-002 SHALL have parameter NCH, default 4, meaning number of probe channels (e.g. Pc, Ir, Operand1, Operand2).
REQ-003 SHALL have parameter DEPTH, default 16, meaning trace entries (power of 2, >=4).
REQ-004 SHALL have parameter POST, default 8, meaning samples captured after the trigger sample (0..DEPTH-1).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port Clock, input, 1 bit, meaning the single clock, rising edge.
REQ-007 SHALL have port Reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-008 SHALL have port Probe, input, NCH*WIDTH bits; channel c is bits [c*WIDTH +: WIDTH].
REQ-009 SHALL have port ProbeValid, input, 1 bit, meaning sample qualifier.
REQ-010 SHALL have port Arm, input, 1 bit, meaning start/restart capture.
REQ-011 SHALL have port TrigMode, input, 2 bits: 00 immediate, 01 equal, 10 not-equal, 11 external.
REQ-012 SHALL have port TrigCh, input, clog2(NCH) bits, meaning the channel compared.
REQ-013 SHALL have port TrigValue, input, WIDTH bits, meaning the compare value.
REQ-014 SHALL have port ExtTrig, input, 1 bit, meaning the external trigger.
REQ-015 SHALL have port Test, input, 1 bit, meaning readout shift enable.
REQ-016 SHALL have port SDI, input, 1 bit, meaning serial in.
REQ-017 SHALL have port SDO, output, 1 bit, meaning serial out.
REQ-018 SHALL have port State, output, 2 bits: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
REQ-019 SHALL have port Count, output, clog2(DEPTH)+1 bits, meaning valid entries.

Function
REQ-020 SHALL enter ARMED and clear the write pointer, Count and readout position when Arm=1 and Test=0, from any state.
REQ-021 SHALL ignore Arm while Test=1.
REQ-022 SHALL, in ARMED or POST with ProbeValid=1, write the full Probe word at the write pointer, increment the pointer modulo DEPTH and saturate Count at DEPTH.
REQ-023 SHALL evaluate the trigger only in ARMED, on a ProbeValid sample:
- immediate: always fires
- equal: fires when channel TrigCh == TrigValue
- not-equal: fires when channel TrigCh != TrigValue
- external: fires when ExtTrig=1
REQ-024 SHALL write the trigger sample itself, then go to POST with the post counter loaded to POST, or go directly to DONE when POST=0.
REQ-025 SHALL, in POST, decrement the post counter on each written sample and enter DONE on the edge that writes the last post sample.
REQ-026 SHALL perform no writes in IDLE or DONE, and Count SHALL hold in those states.
REQ-027 SHALL give Arm priority over ProbeValid and the trigger in the same cycle: the restart occurs and that sample is not written.
REQ-028 SHALL read out oldest-first, starting at entry (wptr - Count) mod DEPTH.
REQ-029 SHALL use an NCH*WIDTH-bit shift register whose bit 0 drives SDO directly.
REQ-030 SHALL, in DONE with Test=1, load the next unread entry on the first edge of each entry slot, then right-shift on the next NCH*WIDTH-1 edges with SDI entering the MSB.
- Bit j of entry k is visible on SDO after edge k*NCH*WIDTH+j+1 of Test-high cycles.
REQ-031 SHALL pause the readout position while Test=0.
REQ-032 SHALL, after all Count entries are read, keep shifting with no further loads, so SDI reappears on SDO after NCH*WIDTH cycles.
REQ-033 SHALL, when Test=1 outside DONE, shift the register as a plain chain with SDI in and SDO out.

Reset
REQ-034 SHALL, while Reset=1, force State=IDLE, Count=0, write pointer=0, post counter=0, shift register=0, SDO=0 and readout position=0, without waiting for a clock edge.
REQ-035 SHALL leave buffer contents undefined after reset and SHALL NOT read them before they are written.

Verification
REQ-036 SHALL be verified by: Reset pulse mid-POST -> same cycle State=0, Count=0, SDO=0; next Arm -> State=1.
REQ-037 SHALL be verified by: defaults, TrigMode=01, TrigCh=0, TrigValue=0x0010, ch0 fed 0x0000, 0x0002, ... one per ProbeValid -> State=3 after 17th sample, Count=16, oldest entry ch0=0x0002, newest=0x0020.
REQ-038 SHALL be verified by: TrigMode=00, 9 samples -> DONE after 9th, Count=9; 10th sample not written.
REQ-039 SHALL be verified by: after the previous case, Test=1 for 576 cycles -> SDO stream equals 9 entries oldest-first, ch0 LSB first; Test toggled low mid-entry -> stream resumes without bit loss.
REQ-040 SHALL be verified by: Arm during POST simultaneous with a ProbeValid -> State=1, Count=0, sample discarded.
REQ-041 SHALL be verified by: TrigMode=11, ExtTrig pulse on the 3rd sample, POST=8 -> DONE after 11th sample, Count=11; Arm with Test=1 -> ignored.
